// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch run/pause/stop/clear sequencer.
//  - sw_state_e : FSM state encoding, visible on the debug/LED state output.
//  - sw_event_e : the single button event acted on in a cycle.
//  - pick_event : priority resolver (clear > stop > pause > start).
//  - TICK_DIV_DEFAULT / DIV_W_DEFAULT : 0.1 s step at 50 MHz.
//  - DIGIT_MAX : largest value held by one BCD digit of the chain.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PAUSED  = 3'd2,
        ST_STOPPED = 3'd3,
        ST_LAP     = 3'd4
    } sw_state_e;

    typedef enum logic [2:0] {
        EV_NONE  = 3'd0,
        EV_START = 3'd1,
        EV_PAUSE = 3'd2,
        EV_STOP  = 3'd3,
        EV_CLEAR = 3'd4
    } sw_event_e;

    localparam int          TICK_DIV_DEFAULT = 5000000;
    localparam int          DIV_W_DEFAULT    = 23;
    localparam logic [3:0]  DIGIT_MAX        = 4'd9;

    // Only the highest-priority event of a cycle survives; the rest are dropped.
    function automatic sw_event_e pick_event(input logic start_ev, input logic pause_ev,
                                             input logic stop_ev, input logic clear_ev);
        sw_event_e ev;
        ev = EV_NONE;
        if (clear_ev)      ev = EV_CLEAR;
        else if (stop_ev)  ev = EV_STOP;
        else if (pause_ev) ev = EV_PAUSE;
        else if (start_ev) ev = EV_START;
        return ev;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the button/digit-chain side and stopwatch_ctrl.
//  master : drives button levels and max_reached, observes the control outputs.
//  slave  : the sequencer itself.
// There is no valid/ready handshake on this bundle: button inputs are plain
// debounced levels sampled every clk, tick/clr are single-cycle pulses the
// digit chain must accept unconditionally, hold/running/state are levels.
interface stopwatch_ctrl_if;
    logic       start_e;
    logic       pause_e;
    logic       stop_e;
    logic       clear_e;
    logic       max_reached;
    logic       tick;
    logic       clr;
    logic       hold;
    logic       running;
    logic [2:0] state;

    modport master (
        output start_e, pause_e, stop_e, clear_e, max_reached,
        input  tick, clr, hold, running, state
    );

    modport slave (
        input  start_e, pause_e, stop_e, clear_e, max_reached,
        output tick, clr, hold, running, state
    );
endinterface

// File: rtl/stopwatch_ctrl_btn_edge.sv
// btn_edge: 1-bit rising-edge detector for a debounced button level.
//  clk     in  system clock
//  reset   in  asynchronous active-low reset
//  level_i in  debounced button level
//  rise_o  out high in the first cycle the level is seen high
// The previous-level register resets to 1 so a button already held down when
// reset is released never produces an event.
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic level_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) prev_q <= 1'b1;
        else        prev_q <= level_i;
    end

    assign rise_o = level_i & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/stop/clear sequencer for the 4-digit 0.1 s stopwatch.
// Owns the 0.1 s prescaler and drives the BCD digit chain.
//  clk          in  system clock
//  reset        in  asynchronous active-low reset
//  sw.start_e   in  debounced start level     sw.tick     out one-cycle count enable
//  sw.pause_e   in  debounced pause level     sw.clr      out one-cycle digit clear
//  sw.stop_e    in  debounced stop level      sw.hold     out display keeps last value
//  sw.clear_e   in  debounced clear level     sw.running  out 1 while in RUN
//  sw.max_reached in digit chain at 9999      sw.state    out FSM state (debug/LEDs)
// Parameters: TICK_DIV (clk cycles per step, >= 2), DIV_W (2**DIV_W >= TICK_DIV).
// Optional feature macro: STOPWATCH_LAP_EN adds the LAP state (pause in RUN
// freezes the display while counting continues).
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT,
    parameter int DIV_W    = DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    stopwatch_ctrl_if.slave  sw
);

    localparam logic [DIV_W-1:0] TERM_CNT = DIV_W'(TICK_DIV - 1);

    sw_state_e        state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             clr_q, clr_d;

    logic             start_ev, pause_ev, stop_ev, clear_ev;
    sw_event_e        ev;
    logic             counting;
    logic             term;

    btn_edge u_start_edge (.clk(clk), .reset(reset), .level_i(sw.start_e), .rise_o(start_ev));
    btn_edge u_pause_edge (.clk(clk), .reset(reset), .level_i(sw.pause_e), .rise_o(pause_ev));
    btn_edge u_stop_edge  (.clk(clk), .reset(reset), .level_i(sw.stop_e),  .rise_o(stop_ev));
    btn_edge u_clear_edge (.clk(clk), .reset(reset), .level_i(sw.clear_e), .rise_o(clear_ev));

    assign ev = pick_event(start_ev, pause_ev, stop_ev, clear_ev);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            clr_q   <= clr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tick_d   = 1'b0;
        clr_d    = 1'b0;
        counting = (state_q == ST_RUN) || (state_q == ST_LAP);
        term     = counting && (cnt_q == TERM_CNT);

        // The prescaler advances in every counting cycle, including the one in
        // which an event is seen; PAUSED then simply freezes it, so a resume
        // continues the interrupted 0.1 s step without losing time.
        if (counting) cnt_d = term ? '0 : cnt_q + 1'b1;

        // A pending tick survives stop/pause events in the same cycle. Clear
        // suppresses it, since the digits are being zeroed and tick/clr must
        // never coincide. At 9999 the terminal count issues no tick.
        if (term && !sw.max_reached && (ev != EV_CLEAR)) tick_d = 1'b1;

        if (ev == EV_CLEAR) begin
            state_d = ST_IDLE;
            clr_d   = 1'b1;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ev == EV_START) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end
                end
                ST_RUN: begin
                    if ((ev == EV_STOP) || (term && sw.max_reached)) begin
                        state_d = ST_STOPPED;
                    end else if (ev == EV_PAUSE) begin
`ifdef STOPWATCH_LAP_EN
                        state_d = ST_LAP;
`else
                        state_d = ST_PAUSED;
`endif
                    end
                end
                ST_PAUSED: begin
                    if ((ev == EV_START) || (ev == EV_PAUSE)) state_d = ST_RUN;
                    else if (ev == EV_STOP)                   state_d = ST_STOPPED;
                end
                ST_STOPPED: begin
                    // Restart from 0000: digits cleared as the count begins.
                    if (ev == EV_START) begin
                        state_d = ST_RUN;
                        clr_d   = 1'b1;
                        cnt_d   = '0;
                    end
                end
`ifdef STOPWATCH_LAP_EN
                ST_LAP: begin
                    if ((ev == EV_STOP) || (term && sw.max_reached)) state_d = ST_STOPPED;
                    else if (ev == EV_PAUSE)                         state_d = ST_RUN;
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign sw.tick    = tick_q;
    assign sw.clr     = clr_q;
    assign sw.running = (state_q == ST_RUN);
`ifdef STOPWATCH_LAP_EN
    assign sw.hold    = (state_q == ST_STOPPED) || (state_q == ST_LAP);
`else
    assign sw.hold    = (state_q == ST_STOPPED);
`endif
    assign sw.state   = state_q;

endmodule
